pio_debounce_irq: RTL

PIO_DEBOUNCE_IRQ -- requirements
Module: pio_debounce_irq

---
 rtl/pio_debounce_irq.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pio_debounce_irq.sv
// pio_debounce_irq: Avalon-MM parallel I/O block with debounced inputs,
// per-channel edge capture, maskable level interrupt and an output register
// with atomic set/clear aliases.
module pio_debounce_irq #(
  parameter int              WIDTH           = 4,
  parameter int              DEBOUNCE_CYCLES = 50000,
  parameter int              EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] OUT_RESET      = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Counter is kept at least one bit wide so the bypass build still elaborates.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((DEBOUNCE_CYCLES > 0) ? DEBOUNCE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [2:0] ADDR_DATA_IN  = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP = 3'd3;
  localparam logic [2:0] ADDR_OUT_SET  = 3'd4;
  localparam logic [2:0] ADDR_OUT_CLR  = 3'd5;

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] stable_reg;
  logic [WIDTH-1:0] stable_next;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_cap_reg;
  logic [WIDTH-1:0] edge_cap_next;
  logic [WIDTH-1:0] cap_clr;
  logic [WIDTH-1:0] irq_mask_reg;
  logic [WIDTH-1:0] data_out_reg;
  logic [WIDTH-1:0] data_out_next;
  logic [WIDTH-1:0] wr_bits;
  logic [31:0]      read_mux;
  logic [31:0]      readdata_reg;
  logic             irq_reg;

  // Upper writedata bits are not stored; fold them here so the intent is explicit.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  assign wr_bits = writedata[WIDTH-1:0];

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= in_port;
      sync2_reg <= sync1_reg;
    end
  end

  // Per-channel debounce: a new level is accepted only after it has been
  // seen for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign stable_next[gi] = sync2_reg[gi];
    end else begin : g_debounce
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             stab_next;

      // Next count and next stable level for this channel.
      always_comb begin
        cnt_next  = '0;
        stab_next = stable_reg[gi];
        if (sync2_reg[gi] != stable_reg[gi]) begin
          if (cnt_reg == CNT_LAST) begin
            stab_next = sync2_reg[gi];
            cnt_next  = '0;
          end else if (cnt_reg != CNT_MAX) begin
            cnt_next = cnt_reg + CNT_ONE;
          end else begin
            cnt_next = cnt_reg;
          end
        end
      end

      // Counter register; reset discards any partial count.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign stable_next[gi] = stab_next;
    end
  end

  // Edge qualification against the configured capture mode.
  if (EDGE_MODE == 1) begin : g_edge_fall
    assign edge_hit = stable_reg & ~stable_next;
  end else if (EDGE_MODE == 2) begin : g_edge_both
    assign edge_hit = stable_reg ^ stable_next;
  end else begin : g_edge_rise
    assign edge_hit = ~stable_reg & stable_next;
  end

  // Write-one-to-clear, with a fresh edge taking priority over the clear.
  always_comb begin
    cap_clr = '0;
    if (write && (address == ADDR_EDGE_CAP)) begin
      cap_clr = wr_bits;
    end
    edge_cap_next = (edge_cap_reg & ~cap_clr) | edge_hit;
  end

  // Output register update from the direct, set and clear addresses.
  always_comb begin
    data_out_next = data_out_reg;
    if (write) begin
      case (address)
        ADDR_DATA_OUT: data_out_next = wr_bits;
        ADDR_OUT_SET:  data_out_next = data_out_reg | wr_bits;
        ADDR_OUT_CLR:  data_out_next = data_out_reg & ~wr_bits;
        default:       data_out_next = data_out_reg;
      endcase
    end
  end

  // Read mux sees pre-write register values, so read-during-write returns old data.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA_IN:  read_mux = 32'(stable_reg);
      ADDR_DATA_OUT: read_mux = 32'(data_out_reg);
      ADDR_IRQ_MASK: read_mux = 32'(irq_mask_reg);
      ADDR_EDGE_CAP: read_mux = 32'(edge_cap_reg);
      default:       read_mux = '0;
    endcase
  end

  // Architectural state, interrupt and read-data registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_reg   <= '0;
      edge_cap_reg <= '0;
      irq_mask_reg <= '0;
      data_out_reg <= OUT_RESET;
      readdata_reg <= '0;
      irq_reg      <= 1'b0;
    end else begin
      stable_reg   <= stable_next;
      edge_cap_reg <= edge_cap_next;
      data_out_reg <= data_out_next;
      if (write && (address == ADDR_IRQ_MASK)) begin
        irq_mask_reg <= wr_bits;
      end
      readdata_reg <= read ? read_mux : 32'd0;
      irq_reg      <= |(edge_cap_reg & irq_mask_reg);
    end
  end

  assign out_port = data_out_reg;
  assign readdata = readdata_reg;
  assign irq      = irq_reg;

endmodule
